// File: rtl/tx_rd_chunk_sched_pkg.sv
// tx_rd_chunk_sched_pkg: shared widths, FSM encoding and descriptor length decode
package tx_rd_chunk_sched_pkg;

    localparam int TAG_W    = 4;
    localparam int NTAGS    = 1 << TAG_W;
    localparam int QW_LEN_W = 9;
    localparam int HP_QW_W  = 19;
    localparam int REM_W    = HP_QW_W + 1;
    localparam int CNT_W    = TAG_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_TAG,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // A zero length field stands for the full 2^18-qword huge page.
    function automatic logic [REM_W-1:0] desc_len(input logic [HP_QW_W-1:0] qw);
        return (qw == '0) ? (REM_W'(1) << (HP_QW_W - 1)) : {1'b0, qw};
    endfunction

endpackage

// File: rtl/tx_rd_chunk_sched_tag_tracker.sv
// tx_tag_tracker: outstanding read tag vector, in-flight count and sticky spurious-completion flag
module tx_tag_tracker
    import tx_rd_chunk_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en_i,
    input  logic [TAG_W-1:0] set_tag_i,
    input  logic             clr_en_i,
    input  logic [TAG_W-1:0] clr_tag_i,
    output logic [CNT_W-1:0] count_o,
    output logic             err_spurious_o
);

    logic [NTAGS-1:0] vec_q, vec_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             clr_hit;

    // Clear is applied before set so a same-tag retire/reissue leaves the bit owned by the new request.
    always_comb begin
        clr_hit = clr_en_i && vec_q[clr_tag_i];
        vec_d   = (vec_q & ~(clr_hit ? (NTAGS'(1) << clr_tag_i) : '0))
                | (set_en_i ? (NTAGS'(1) << set_tag_i) : '0);
        cnt_d   = cnt_q - CNT_W'(clr_hit) + CNT_W'(set_en_i);
        err_d   = err_q | (clr_en_i && !vec_q[clr_tag_i]);
    end

    // Tracker state register; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            vec_q <= vec_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign count_o        = cnt_q;
    assign err_spurious_o = err_q;

endmodule

// File: rtl/tx_rd_chunk_sched.sv
// tx_rd_chunk_sched: splits a huge-page descriptor into chunk read requests and signals page completion
module tx_rd_chunk_sched
    import tx_rd_chunk_sched_pkg::*;
#(
    parameter int CHUNK_QW        = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                trn_clk,
    input  logic                reset,
    input  logic                hp_desc_valid,
    input  logic [63:0]         hp_desc_addr,
    input  logic [HP_QW_W-1:0]  hp_desc_qw,
    output logic                hp_desc_ready,
    output logic [63:0]         huge_page_addr,
    output logic [QW_LEN_W-1:0] qwords_to_rd,
    output logic                read_chunk,
    input  logic                read_chunk_ack,
    input  logic [TAG_W-1:0]    tlp_tag,
    output logic                send_rd_completed,
    input  logic                send_rd_completed_ack,
    input  logic                cpl_done,
    input  logic [TAG_W-1:0]    cpl_tag,
    output logic                busy,
    output logic                err_spurious_cpl
);

    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
    localparam logic [REM_W-1:0] CHUNK_REM = REM_W'(CHUNK_QW);

    state_t              state_q, state_d;
    logic [63:0]         addr_q, addr_d;
    logic [REM_W-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0]    count;
    logic [QW_LEN_W-1:0] cur_len;

    // Request outputs come straight from registered state so they hold steady until acked.
    always_comb begin
        cur_len           = (rem_q > CHUNK_REM) ? QW_LEN_W'(CHUNK_QW) : rem_q[QW_LEN_W-1:0];
        read_chunk        = (state_q == ST_ISSUE) && (count < MAX_CNT);
        send_rd_completed = (state_q == ST_DONE);
        hp_desc_ready     = (state_q == ST_IDLE);
        busy              = (state_q != ST_IDLE);
        huge_page_addr    = addr_q;
        qwords_to_rd      = cur_len;
    end

    // Next-state and address/remaining-length datapath.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (hp_desc_valid) begin
                    addr_d  = hp_desc_addr;
                    rem_d   = desc_len(hp_desc_qw);
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (read_chunk && read_chunk_ack) begin
                    addr_d  = addr_q + {{(64-QW_LEN_W-3){1'b0}}, cur_len, 3'b000};
                    rem_d   = rem_q - {{(REM_W-QW_LEN_W){1'b0}}, cur_len};
                    state_d = ST_WAIT_TAG;
                end
            end
            ST_WAIT_TAG: state_d = (rem_q != '0) ? ST_ISSUE : ST_DRAIN;
            ST_DRAIN:    state_d = (count == '0) ? ST_DONE : ST_DRAIN;
            ST_DONE:     state_d = send_rd_completed_ack ? ST_IDLE : ST_DONE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers.
    always_ff @(posedge trn_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    tx_tag_tracker u_tags (
        .clk            (trn_clk),
        .rst            (reset),
        .set_en_i       (state_q == ST_WAIT_TAG),
        .set_tag_i      (tlp_tag),
        .clr_en_i       (cpl_done),
        .clr_tag_i      (cpl_tag),
        .count_o        (count),
        .err_spurious_o (err_spurious_cpl)
    );

endmodule
